// File: rtl/matrix_ls_sequencer_pkg.sv
// rtl/matrix_ls_sequencer_pkg.sv - shared types for the matrix load/store sequencer
package matrix_ls_sequencer_pkg;

    typedef enum logic [1:0] {
        LS_NONE  = 2'b00,
        LS_LOAD  = 2'b01,
        LS_STORE = 2'b10
    } ls_e;

    typedef logic [3:0]  mreg_t;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DONE
    } state_e;

    function automatic word_t sext_imm(input logic [10:0] imm);
        return {{21{imm[10]}}, imm};
    endfunction

endpackage

// File: rtl/matrix_ls_addr_gen.sv
// rtl/matrix_ls_addr_gen.sv - per-row address/row registers with stride stepping
module matrix_ls_addr_gen
    import matrix_ls_sequencer_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int ROW_W = $clog2(ROWS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             init_i,
    input  logic             step_i,
    input  word_t            base_i,
    input  word_t            stride_i,
    input  logic [10:0]      imm_i,
    output word_t            addr_o,
    output logic [ROW_W-1:0] row_o,
    output logic             last_o
);

    word_t            addr_q, addr_d;
    word_t            stride_q, stride_d;
    logic [ROW_W-1:0] row_q, row_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q   <= '0;
            stride_q <= '0;
            row_q    <= '0;
        end else begin
            addr_q   <= addr_d;
            stride_q <= stride_d;
            row_q    <= row_d;
        end
    end

    // Address arithmetic wraps modulo 2^32 by construction.
    always_comb begin
        addr_d   = addr_q;
        stride_d = stride_q;
        row_d    = row_q;
        if (init_i) begin
            addr_d   = base_i + sext_imm(imm_i);
            stride_d = stride_i;
            row_d    = '0;
        end else if (step_i) begin
            addr_d = addr_q + stride_q;
            row_d  = row_q + 1'b1;
        end
    end

    assign addr_o = addr_q;
    assign row_o  = row_q;
    assign last_o = (row_q == ROW_W'(ROWS - 1));

endmodule

// File: rtl/matrix_ls_sequencer.sv
// rtl/matrix_ls_sequencer.sv - expands one matrix load/store op into per-row scratchpad requests; MLS_TIMEOUT_EN adds a per-row timeout
module matrix_ls_sequencer
    import matrix_ls_sequencer_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int ROW_W = $clog2(ROWS)
`ifdef MLS_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 256
`endif
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             enable,
    output logic             ready,
    input  logic [1:0]       ls_in,
    input  logic [3:0]       rd_in,
    input  logic [31:0]      base_in,
    input  logic [31:0]      stride_in,
    input  logic [10:0]      imm_in,
    input  logic             flush,
    output logic             sp_req,
    output logic             sp_ren,
    output logic             sp_wen,
    output logic [31:0]      sp_addr,
    output logic [3:0]       sp_mreg,
    output logic [ROW_W-1:0] sp_row,
    input  logic             mhit,
    output logic             done,
    output logic [3:0]       done_rd,
    output logic             err
);

    state_e state_q, state_d;
    ls_e    ls_q;
    mreg_t  rd_q;
    logic   err_q, err_d;
    logic   legal, accept, step, last, timeout_hit;

    assign legal  = (ls_in == LS_LOAD) || (ls_in == LS_STORE);
    assign accept = (state_q == ST_IDLE) && enable && !flush && legal;
    assign step   = (state_q == ST_ISSUE) && mhit && !flush && !last;

`ifdef MLS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter sits at zero outside ISSUE, so entering ISSUE starts it cleared.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (state_q != ST_ISSUE || mhit) cnt_d = '0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign timeout_hit = (state_q == ST_ISSUE) && !mhit && (cnt_q == CW'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    matrix_ls_addr_gen #(.ROWS(ROWS), .ROW_W(ROW_W)) u_addr_gen (
        .clk_i    (CLK),
        .rst_ni   (nRST),
        .init_i   (accept),
        .step_i   (step),
        .base_i   (base_in),
        .stride_i (stride_in),
        .imm_i    (imm_in),
        .addr_o   (sp_addr),
        .row_o    (sp_row),
        .last_o   (last)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            ls_q    <= LS_NONE;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (accept) begin
                ls_q <= ls_e'(ls_in);
                rd_q <= rd_in;
            end
        end
    end

    // Flush wins over everything, including a coincident mhit or timeout.
    always_comb begin
        state_d = state_q;
        err_d   = !flush && (((state_q == ST_IDLE) && enable && !legal) || timeout_hit);
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (accept) state_d = ST_ISSUE;
                ST_ISSUE: begin
                    if (timeout_hit)      state_d = ST_IDLE;
                    else if (mhit && last) state_d = ST_DONE;
                end
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ready   = (state_q == ST_IDLE);
        sp_req  = (state_q == ST_ISSUE);
        sp_ren  = (state_q == ST_ISSUE) && (ls_q == LS_LOAD);
        sp_wen  = (state_q == ST_ISSUE) && (ls_q == LS_STORE);
        sp_mreg = rd_q;
        done    = (state_q == ST_DONE);
        done_rd = (state_q == ST_DONE) ? rd_q : '0;
        err     = err_q;
    end

endmodule

// File: tb/tb_matrix_ls_sequencer.sv
// tb/tb_matrix_ls_sequencer.sv - directed self-checking bench for matrix_ls_sequencer
module tb_matrix_ls_sequencer;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        enable;
    logic        ready;
    logic [1:0]  ls_in;
    logic [3:0]  rd_in;
    logic [31:0] base_in;
    logic [31:0] stride_in;
    logic [10:0] imm_in;
    logic        flush;
    logic        sp_req;
    logic        sp_ren;
    logic        sp_wen;
    logic [31:0] sp_addr;
    logic [3:0]  sp_mreg;
    logic [1:0]  sp_row;
    logic        mhit;
    logic        done;
    logic [3:0]  done_rd;
    logic        err;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 CLK = ~CLK;

`ifdef MLS_TIMEOUT_EN
    matrix_ls_sequencer #(.ROWS(4), .TIMEOUT(8)) dut (
`else
    matrix_ls_sequencer #(.ROWS(4)) dut (
`endif
        .CLK       (CLK),
        .nRST      (nRST),
        .enable    (enable),
        .ready     (ready),
        .ls_in     (ls_in),
        .rd_in     (rd_in),
        .base_in   (base_in),
        .stride_in (stride_in),
        .imm_in    (imm_in),
        .flush     (flush),
        .sp_req    (sp_req),
        .sp_ren    (sp_ren),
        .sp_wen    (sp_wen),
        .sp_addr   (sp_addr),
        .sp_mreg   (sp_mreg),
        .sp_row    (sp_row),
        .mhit      (mhit),
        .done      (done),
        .done_rd   (done_rd),
        .err       (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] ls, input logic [3:0] rd, input logic [31:0] base,
                            input logic [31:0] stride, input logic [10:0] imm);
        ls_in     = ls;
        rd_in     = rd;
        base_in   = base;
        stride_in = stride;
        imm_in    = imm;
        enable    = 1'b1;
        @(negedge CLK);
        enable    = 1'b0;
    endtask

    // Expects a full op on rows 0..3 starting at a0, acking each row after dly idle cycles.
    task automatic run_rows(input logic [31:0] a0, input logic [31:0] stride, input int dly,
                            input logic ld, input logic [3:0] rd);
        logic [31:0] exp_addr;
        for (int r = 0; r < 4; r++) begin
            exp_addr = a0 + stride * 32'(r);
            for (int d = 0; d < dly; d++) begin
                mhit = 1'b0;
                check_eq("hold_addr", sp_addr, exp_addr);
                check_eq("hold_row", 32'(sp_row), 32'(r));
                @(negedge CLK);
            end
            check_eq("addr", sp_addr, exp_addr);
            check_eq("row", 32'(sp_row), 32'(r));
            check_eq("req", 32'(sp_req), 32'd1);
            check_eq("ren", 32'(sp_ren), 32'(ld));
            check_eq("wen", 32'(sp_wen), 32'(!ld));
            check_eq("mreg", 32'(sp_mreg), 32'(rd));
            check_eq("done_early", 32'(done), 32'd0);
            mhit = 1'b1;
            @(negedge CLK);
            mhit = 1'b0;
        end
        check_eq("done", 32'(done), 32'd1);
        check_eq("done_rd", 32'(done_rd), 32'(rd));
        check_eq("req_in_done", 32'(sp_req), 32'd0);
        check_eq("ready_in_done", 32'(ready), 32'd0);
        @(negedge CLK);
        check_eq("done_pulse", 32'(done), 32'd0);
        check_eq("ready_after", 32'(ready), 32'd1);
    endtask

    initial begin
        nRST = 1'b0; enable = 1'b0; ls_in = 2'b00; rd_in = 4'd0; base_in = '0;
        stride_in = '0; imm_in = '0; flush = 1'b0; mhit = 1'b0;
        repeat (2) @(negedge CLK);
        check_eq("rst_ready", 32'(ready), 32'd1);
        check_eq("rst_req", 32'(sp_req), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_addr", sp_addr, 32'd0);
        check_eq("rst_done_rd", 32'(done_rd), 32'd0);
        nRST = 1'b1;
        @(negedge CLK);

        // Load, mhit every cycle
        start_op(2'b01, 4'd3, 32'h1000, 32'h20, 11'h010);
        run_rows(32'h1010, 32'h20, 0, 1'b1, 4'd3);

        // Store with negative immediate, 3-cycle mhit delay
        start_op(2'b10, 4'd7, 32'h100, 32'h40, 11'h7F0);
        run_rows(32'hF0, 32'h40, 3, 1'b0, 4'd7);

        // Address wrap
        start_op(2'b01, 4'd1, 32'hFFFF_FFF0, 32'h10, 11'h000);
        run_rows(32'hFFFF_FFF0, 32'h10, 0, 1'b1, 4'd1);

        // Zero stride
        start_op(2'b10, 4'd2, 32'h4000, 32'h0, 11'h004);
        run_rows(32'h4004, 32'h0, 1, 1'b0, 4'd2);

        // Illegal ls_in values
        ls_in = 2'b11; enable = 1'b1;
        @(negedge CLK);
        enable = 1'b0;
        check_eq("ill11_err", 32'(err), 32'd1);
        check_eq("ill11_req", 32'(sp_req), 32'd0);
        check_eq("ill11_ready", 32'(ready), 32'd1);
        @(negedge CLK);
        check_eq("ill11_err_pulse", 32'(err), 32'd0);
        check_eq("ill11_req2", 32'(sp_req), 32'd0);
        ls_in = 2'b00; enable = 1'b1;
        @(negedge CLK);
        enable = 1'b0;
        check_eq("ill00_err", 32'(err), 32'd1);
        check_eq("ill00_req", 32'(sp_req), 32'd0);

        // Enable while busy is ignored
        start_op(2'b01, 4'd4, 32'h800, 32'h8, 11'h000);
        ls_in = 2'b10; rd_in = 4'd9; base_in = 32'h9999_0000; enable = 1'b1;
        @(negedge CLK);
        check_eq("busy_ready", 32'(ready), 32'd0);
        check_eq("busy_addr", sp_addr, 32'h800);
        check_eq("busy_ren", 32'(sp_ren), 32'd1);
        enable = 1'b0;
        run_rows(32'h800, 32'h8, 0, 1'b1, 4'd4);
        @(negedge CLK);
        check_eq("busy_no_second_req", 32'(sp_req), 32'd0);
        check_eq("busy_no_second_done", 32'(done), 32'd0);

        // Flush on row 2 with coincident mhit
        start_op(2'b01, 4'd5, 32'h2000, 32'h4, 11'h000);
        mhit = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check_eq("flush_row2", 32'(sp_row), 32'd2);
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0; mhit = 1'b0;
        check_eq("flush_req", 32'(sp_req), 32'd0);
        check_eq("flush_done", 32'(done), 32'd0);
        check_eq("flush_ready", 32'(ready), 32'd1);
        @(negedge CLK);
        check_eq("flush_done2", 32'(done), 32'd0);
        start_op(2'b01, 4'd6, 32'h3000, 32'h100, 11'h000);
        run_rows(32'h3000, 32'h100, 0, 1'b1, 4'd6);

        // Flush in IDLE blocks acceptance
        flush = 1'b1;
        start_op(2'b01, 4'd8, 32'h10, 32'h4, 11'h000);
        flush = 1'b0;
        check_eq("flush_idle_req", 32'(sp_req), 32'd0);
        check_eq("flush_idle_ready", 32'(ready), 32'd1);

        // Reset mid-op
        start_op(2'b10, 4'd11, 32'h5000, 32'h4, 11'h000);
        mhit = 1'b1;
        @(negedge CLK);
        mhit = 1'b0;
        #2 nRST = 1'b0;
        #1;
        check_eq("rst_mid_req", 32'(sp_req), 32'd0);
        check_eq("rst_mid_wen", 32'(sp_wen), 32'd0);
        check_eq("rst_mid_addr", sp_addr, 32'd0);
        check_eq("rst_mid_row", 32'(sp_row), 32'd0);
        check_eq("rst_mid_mreg", 32'(sp_mreg), 32'd0);
        check_eq("rst_mid_ready", 32'(ready), 32'd1);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);

`ifdef MLS_TIMEOUT_EN
        start_op(2'b01, 4'd12, 32'h6000, 32'h4, 11'h000);
        for (int i = 0; i < 8; i++) begin
            check_eq("to_req_held", 32'(sp_req), 32'd1);
            check_eq("to_err_quiet", 32'(err), 32'd0);
            @(negedge CLK);
        end
        check_eq("to_err", 32'(err), 32'd1);
        check_eq("to_req", 32'(sp_req), 32'd0);
        check_eq("to_done", 32'(done), 32'd0);
        check_eq("to_ready", 32'(ready), 32'd1);
`else
        start_op(2'b01, 4'd12, 32'h6000, 32'h4, 11'h000);
        repeat (20) @(negedge CLK);
        check_eq("wait_req_held", 32'(sp_req), 32'd1);
        check_eq("wait_no_err", 32'(err), 32'd0);
        check_eq("wait_row0", 32'(sp_row), 32'd0);
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        check_eq("wait_flush_ready", 32'(ready), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
